fetch_sequencer: RTL
====================

# fetch_sequencer

Instruction fetch controller that sequences the combinational instruction ROM of the single-cycle MIPS core. It owns the program counter, drives the ROM address, and buffers fetched words in a 2-entry queue. Words leave through a valid/ready handshake toward decode. It also handles jump/branch redirects and flags unmapped fetches. A self-jump idle loop stops fetching.

## Interface
Parameters:
- RESET_PC, 32'h0000_0000, first fetch address after reset; must be word-aligned.
- QDEPTH, 2, output queue depth; legal values are 1 and 2.

Ports:
- clk  in  1  system clock; all state changes on its rising edge.
- rst_n  in  1  reset, synchronous, active-low.
- imem_addr  out  32  ROM address; combinational, equal to pc.
- imem_word  in  32  ROM data for imem_addr, same cycle.
- redirect_valid  in  1  load new PC this cycle.
- redirect_target  in  32  new PC.
- instr_valid  out  1  queue head is valid.
- instr_ready  in  1  decode accepts the head.
- instr_word  out  32  head instruction.
- instr_pc  out  32  head address.
- halted  out  1  self-jump detected; fetching stopped.
- fetch_fault  out  1  unmapped fetch or misaligned redirect.
- fault_pc  out  32  offending address; valid while fetch_fault=1.

## Operation
- State machine has three states: FS_RUN, FS_HALT and FS_FAULT.
- Fetch condition: state is FS_RUN, no redirect, and the queue is not full after this cycle's pop.
  - Pop-aware: a full queue with instr_valid&instr_ready high still fetches.
- A fetch enqueues {pc, imem_word} and sets pc <= pc+4, modulo 2^32 (0xFFFF_FFFC wraps to 0).
- When the fetch condition is false, pc holds and nothing is enqueued.
- Unmapped fetch: imem_word == 32'hFFFF_FFFF.
  - The word is not enqueued and pc holds.
  - fault_pc <= pc, then go to FS_FAULT.
  - Entries already queued still drain.
- Self-jump: imem_word[31:26]==6'b000010 and {pc[31:28], imem_word[25:0], 2'b00} == pc.
  - The word is enqueued and pc holds.
  - Go to FS_HALT (requires the macro; see Configuration).
- Redirect has the highest priority.
  - A handshake in the redirect cycle completes; every other entry is flushed.
  - The fetch in that cycle is discarded.
  - If redirect_target[1:0] != 0: fault_pc <= target, pc <= target, go to FS_FAULT.
  - Otherwise pc <= target and go to FS_RUN, from any state.
- FS_HALT and FS_FAULT are left only by a redirect or by reset.
- Status outputs: halted = (state==FS_HALT); fetch_fault = (state==FS_FAULT).

## Timing
- Reset values: pc=RESET_PC, queue empty, instr_valid=0, instr_word=0, instr_pc=0, halted=0, fetch_fault=0, fault_pc=0, state FS_RUN.
- Reset asserted mid-operation discards all queue contents on that edge.
- Fetch latency: a word fetched in cycle N is on instr_valid/instr_word in cycle N+1.
  - The first instruction is visible in the first cycle after rst_n rises.
- Throughput is 1 instruction per cycle while instr_ready=1.
- Handshake rules:
  - instr_word and instr_pc are stable while instr_valid=1 and instr_ready=0.
  - instr_valid never drops without a handshake, except on redirect or reset.
- Redirect in cycle N:
  - instr_valid=0 in cycle N+1.
  - The instruction at target is valid in cycle N+2.
- halted and fetch_fault assert in the cycle after the triggering fetch or redirect.

## Configuration
- FETCH_HALT_DETECT_EN defined:
  - Self-jump detection is active, as described above.
- Not defined:
  - A self-jump is an ordinary instruction; fetching continues, re-fetching the same word each cycle.
  - halted is tied to 0 and FS_HALT is unreachable.
- Fault detection is unaffected by the macro.

## Structure
- Package fetch_pkg:
  - typedef enum fetch_state_t {FS_RUN, FS_HALT, FS_FAULT}.
  - typedef struct fetch_entry_t {pc[31:0], word[31:0]}.
  - Constants OPC_J=6'b000010 and IMEM_UNMAPPED=32'hFFFF_FFFF.
- Sub-module fetch_queue:
  - QDEPTH-entry FIFO of fetch_entry_t.
  - Ports: push, pop, flush, full, empty, head.
  - flush empties the queue the same cycle, while honouring that cycle's pop.
- Top level holds the pc, the FSM, the decode logic and the fault/halt registers.

## Test plan
- Reset release, ROM words at 0,4,8, instr_ready=1 -> instr_pc sequence 0,4,8 on consecutive cycles starting the first cycle after reset.
- instr_ready=0 for 5 cycles from pc=0 -> 2 entries queued (0,4), pc holds at 8, head stable; ready=1 -> 0,4,8 delivered back-to-back.
- ROM word 32'h0800_0020 at address 128 (self-jump), macro defined:
  - instr at 128 delivered, halted=1 next cycle, imem_addr stays 128.
  - redirect to 0 -> halted=0 and instr_pc=0 two cycles later.
  - Macro undefined: 128 repeats every cycle and halted stays 0.
- Fetch at address 160 returning 32'hFFFF_FFFF -> not delivered, fetch_fault=1, fault_pc=160, earlier entries still drain.
- Redirect to 0x42 -> fetch_fault=1, fault_pc=0x42; then redirect to 0x40 -> fault clears, instr_pc=0x40 two cycles later.
- Queue full, redirect and handshake in the same cycle -> head accepted once, remaining entry flushed, instr_valid=0 next cycle; rst_n=0 mid-stream -> all outputs at reset values next cycle.

Source files
------------

// File: rtl/fetch_pkg.sv
`default_nettype none
// ============================================================================
// Module   : fetch_pkg
// Purpose  : Shared types and constants for the instruction fetch sequencer.
// Revision : 1.0 - initial release
// ============================================================================
package fetch_pkg;

  // Fetch controller operating states
  typedef enum logic [1:0] {
    FS_RUN   = 2'd0,
    FS_HALT  = 2'd1,
    FS_FAULT = 2'd2
  } fetch_state_t;

  // One buffered fetch: address and the word read from it
  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] word;
  } fetch_entry_t;

  localparam logic [5:0]  OPC_J         = 6'b000010;
  localparam logic [31:0] IMEM_UNMAPPED = 32'hFFFF_FFFF;

  // A J instruction whose pseudo-direct target is its own address
  function automatic logic is_self_jump(input logic [31:0] pc, input logic [31:0] word);
    return (word[31:26] == OPC_J) && ({pc[31:28], word[25:0], 2'b00} == pc);
  endfunction

endpackage
`default_nettype wire

// File: rtl/fetch_queue.sv
`default_nettype none
// ============================================================================
// Module   : fetch_queue
// Purpose  : QDEPTH-entry FIFO of fetched words; entry 0 is always the head.
//            flush empties the queue in the same cycle (a concurrent pop is
//            simply absorbed by the flush).
// Revision : 1.0 - initial release
// ============================================================================
module fetch_queue
  import fetch_pkg::*;
#(
  parameter int QDEPTH = 2
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push,
  input  fetch_entry_t push_data,
  input  logic         pop,
  input  logic         flush,
  output logic         full,
  output logic         empty,
  output fetch_entry_t head
);

  localparam int CW = $clog2(QDEPTH + 1);

  fetch_entry_t  r_mem [QDEPTH];
  logic [CW-1:0] r_count;

  fetch_entry_t  w_mem_next [QDEPTH];
  logic [CW-1:0] w_count_next;
  logic [CW-1:0] w_wr_idx;

  // Shift on pop, write the new entry behind the surviving ones
  always_comb begin
    w_wr_idx = r_count - CW'(pop);
    for (int i = 0; i < QDEPTH; i++) begin
      w_mem_next[i] = r_mem[i];
    end
    if (pop) begin
      for (int i = 0; i < QDEPTH - 1; i++) begin
        w_mem_next[i] = r_mem[i + 1];
      end
    end
    for (int i = 0; i < QDEPTH; i++) begin
      if (push && (CW'(i) == w_wr_idx)) begin
        w_mem_next[i] = push_data;
      end
    end
    if (flush) begin
      w_count_next = '0;
    end else begin
      w_count_next = r_count - CW'(pop) + CW'(push);
    end
  end

  // Storage and occupancy registers; reset clears contents so the head reads zero
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_count <= '0;
      for (int i = 0; i < QDEPTH; i++) begin
        r_mem[i] <= '0;
      end
    end else begin
      r_count <= w_count_next;
      for (int i = 0; i < QDEPTH; i++) begin
        r_mem[i] <= w_mem_next[i];
      end
    end
  end

  assign full  = (r_count == CW'(QDEPTH));
  assign empty = (r_count == '0);
  assign head  = r_mem[0];

endmodule
`default_nettype wire

// File: rtl/fetch_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : fetch_sequencer
// Purpose  : Drives the combinational instruction ROM, owns the PC, buffers
//            fetched words toward decode, handles redirects, flags unmapped
//            fetches / misaligned targets. Define FETCH_HALT_DETECT_EN to stop
//            fetching on a self-jump idle loop.
// Revision : 1.0 - initial release
// ============================================================================
module fetch_sequencer
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          QDEPTH   = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_word,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_target,
  output logic        instr_valid,
  input  logic        instr_ready,
  output logic [31:0] instr_word,
  output logic [31:0] instr_pc,
  output logic        halted,
  output logic        fetch_fault,
  output logic [31:0] fault_pc
);

`ifdef FETCH_HALT_DETECT_EN
  localparam bit c_HALT_EN = 1'b1;
`else
  localparam bit c_HALT_EN = 1'b0;
`endif

  fetch_state_t r_state, w_state_next;
  logic [31:0]  r_pc, w_pc_next;
  logic [31:0]  r_fault_pc, w_fault_pc_next;

  logic         w_push, w_pop, w_full, w_empty, w_fetch;
  fetch_entry_t w_head;

  // Redirect wins; otherwise fetch when running and the queue has room after this pop
  always_comb begin
    w_state_next    = r_state;
    w_pc_next       = r_pc;
    w_fault_pc_next = r_fault_pc;
    w_push          = 1'b0;
    w_pop           = !w_empty && instr_ready;
    w_fetch         = (r_state == FS_RUN) && !redirect_valid && (!w_full || w_pop);
    if (redirect_valid) begin
      w_pc_next = redirect_target;
      if (redirect_target[1:0] != 2'b00) begin
        w_state_next    = FS_FAULT;
        w_fault_pc_next = redirect_target;
      end else begin
        w_state_next = FS_RUN;
      end
    end else if (w_fetch) begin
      if (imem_word == IMEM_UNMAPPED) begin
        w_state_next    = FS_FAULT;
        w_fault_pc_next = r_pc;
      end else begin
        w_push = 1'b1;
        if (is_self_jump(r_pc, imem_word)) begin
          // PC holds on a self-jump; only the halt transition is optional
          if (c_HALT_EN) begin
            w_state_next = FS_HALT;
          end
        end else begin
          w_pc_next = r_pc + 32'd4;
        end
      end
    end
  end

  // State, PC and fault address registers
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state    <= FS_RUN;
      r_pc       <= RESET_PC;
      r_fault_pc <= '0;
    end else begin
      r_state    <= w_state_next;
      r_pc       <= w_pc_next;
      r_fault_pc <= w_fault_pc_next;
    end
  end

  fetch_queue #(
    .QDEPTH (QDEPTH)
  ) u_queue (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (w_push),
    .push_data ({r_pc, imem_word}),
    .pop       (w_pop),
    .flush     (redirect_valid),
    .full      (w_full),
    .empty     (w_empty),
    .head      (w_head)
  );

  assign imem_addr   = r_pc;
  assign instr_valid = !w_empty;
  assign instr_word  = w_head.word;
  assign instr_pc    = w_head.pc;
  assign halted      = c_HALT_EN && (r_state == FS_HALT);
  assign fetch_fault = (r_state == FS_FAULT);
  assign fault_pc    = r_fault_pc;

endmodule
`default_nettype wire
